// File: rtl/arbitro_comparador.sv
// Round-robin arbiter that time-shares one external 2-bit equality comparator among NREQ requesters,
// returning each result over a 4-phase req/ack handshake. Optional statistics counters: ARB_CMP_STATS_EN.
module arbitro_comparador #(
  parameter int NREQ = 4,
  parameter int W    = 2,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_bus,
  input  logic [NREQ*W-1:0] b_bus,
  output logic [NREQ-1:0]   ack,
  output logic              res,
  output logic [IDW-1:0]    gnt_id,
  output logic              busy,
  output logic [W-1:0]      cmp_a,
  output logic [W-1:0]      cmp_b,
  input  logic              cmp_aeqb
`ifdef ARB_CMP_STATS_EN
  ,
  output logic [15:0]       n_cmp,
  output logic [15:0]       n_eq
`endif
);

  typedef enum logic [1:0] {IDLE, COMPARE, HOLD} state_t;

  localparam logic [IDW:0] NREQ_V = (IDW+1)'(NREQ);

  state_t          state_q, state_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            res_q, res_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [W-1:0]    cmp_a_q, cmp_a_d;
  logic [W-1:0]    cmp_b_q, cmp_b_d;
`ifdef ARB_CMP_STATS_EN
  logic [15:0]     n_cmp_q, n_cmp_d;
  logic [15:0]     n_eq_q, n_eq_d;
`endif

  logic [W-1:0]    a_slice [NREQ];
  logic [W-1:0]    b_slice [NREQ];
  logic            sel_found;
  logic [IDW-1:0]  sel_id;
  logic [IDW:0]    cand;
  logic [IDW:0]    ptr_inc;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign a_slice[gi] = a_bus[gi*W +: W];
      assign b_slice[gi] = b_bus[gi*W +: W];
    end
  endgenerate

  // Scan from the highest offset down so the candidate closest to ptr is the last one written.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= NREQ_V) cand = cand - NREQ_V;
      if (req[cand[IDW-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    ptr_inc = {1'b0, gnt_id_q} + (IDW+1)'(1);
    if (ptr_inc >= NREQ_V) ptr_inc = '0;
  end

  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    res_d    = res_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    cmp_a_d  = cmp_a_q;
    cmp_b_d  = cmp_b_q;
`ifdef ARB_CMP_STATS_EN
    n_cmp_d  = n_cmp_q;
    n_eq_d   = n_eq_q;
`endif
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          gnt_id_d = sel_id;
          cmp_a_d  = a_slice[sel_id];
          cmp_b_d  = b_slice[sel_id];
          state_d  = COMPARE;
        end
      end
      COMPARE: begin
        res_d           = cmp_aeqb;
        ack_d           = '0;
        ack_d[gnt_id_q] = 1'b1;
        state_d         = HOLD;
`ifdef ARB_CMP_STATS_EN
        n_cmp_d = n_cmp_q + 16'd1;
        if (cmp_aeqb) n_eq_d = n_eq_q + 16'd1;
`endif
      end
      HOLD: begin
        if (!req[gnt_id_q]) begin
          ack_d   = '0;
          ptr_d   = ptr_inc[IDW-1:0];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ack_q    <= '0;
      res_q    <= 1'b0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      cmp_a_q  <= '0;
      cmp_b_q  <= '0;
`ifdef ARB_CMP_STATS_EN
      n_cmp_q  <= '0;
      n_eq_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      res_q    <= res_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      cmp_a_q  <= cmp_a_d;
      cmp_b_q  <= cmp_b_d;
`ifdef ARB_CMP_STATS_EN
      n_cmp_q  <= n_cmp_d;
      n_eq_q   <= n_eq_d;
`endif
    end
  end

  assign ack    = ack_q;
  assign res    = res_q;
  assign gnt_id = gnt_id_q;
  assign busy   = (state_q != IDLE);
  assign cmp_a  = cmp_a_q;
  assign cmp_b  = cmp_b_q;
`ifdef ARB_CMP_STATS_EN
  assign n_cmp  = n_cmp_q;
  assign n_eq   = n_eq_q;
`endif

endmodule

// File: tb/tb_arbitro_comparador.sv
// Self-checking bench for arbitro_comparador: vector table plus scoreboard, with hand-written
// sequences for round robin, operand change after grant, abort and reset mid-transaction.
module tb_arbitro_comparador;
  localparam int NREQ = 4;
  localparam int W    = 2;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_bus;
  logic [NREQ*W-1:0] b_bus;
  logic [NREQ-1:0]   ack;
  logic              res;
  logic [IDW-1:0]    gnt_id;
  logic              busy;
  logic [W-1:0]      cmp_a;
  logic [W-1:0]      cmp_b;
  logic              cmp_aeqb;

  arbitro_comparador #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .ack(ack), .res(res), .gnt_id(gnt_id), .busy(busy),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_aeqb(cmp_aeqb)
  );

  always #5 clk = ~clk;

  // The shared comparator itself
  assign cmp_aeqb = (cmp_a == cmp_b);

  typedef struct {
    logic [NREQ-1:0] req;
    int              slot;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [IDW-1:0]  gnt;
    logic            res;
    logic [NREQ-1:0] ack;
  } vec_t;

  typedef struct {
    logic [IDW-1:0]  gnt;
    logic            res;
    logic [NREQ-1:0] ack;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_txn = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ack(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ack != '0) begin
        cycles = i;
        break;
      end
    end
  endtask

  // Called right after a negedge; returns right after a negedge with the FSM back in IDLE.
  task automatic run_txn(input logic [NREQ-1:0] r, input logic [NREQ*W-1:0] ab,
                         input logic [NREQ*W-1:0] bb, input exp_t e, input bit drop_all);
    int   cyc;
    exp_t got;
    req   = r;
    a_bus = ab;
    b_bus = bb;
    sb.push_back(e);
    wait_ack(cyc);
    check("latency", 32'(cyc), 32'd2);
    got = sb.pop_front();
    check("ack", 32'(ack), 32'(got.ack));
    check("res", 32'(res), 32'(got.res));
    check("gnt_id", 32'(gnt_id), 32'(got.gnt));
    check("cmp_a", 32'(cmp_a), 32'(got.a));
    check("cmp_b", 32'(cmp_b), 32'(got.b));
    n_txn++;
    $display("txn %0d req=%b gnt=%0d res=%0d ack=%b", n_txn, r, gnt_id, res, ack);
    req = drop_all ? '0 : (r & ~got.ack);
    @(negedge clk);
    check("ack_release", 32'(ack), 32'd0);
    check("busy_release", 32'(busy), 32'd0);
  endtask

  function automatic logic [NREQ*W-1:0] put_slot(input logic [NREQ*W-1:0] bus, input int s,
                                                 input logic [W-1:0] v);
    logic [NREQ*W-1:0] o;
    o = bus;
    o[s*W +: W] = v;
    return o;
  endfunction

  vec_t vecs[6];
  exp_t e;
  logic [NREQ*W-1:0] ab, bb;

  initial begin
    vecs[0] = '{req: 4'b0001, slot: 0, a: 2'd2, b: 2'd2, gnt: 2'd0, res: 1'b1, ack: 4'b0001};
    vecs[1] = '{req: 4'b0100, slot: 2, a: 2'd1, b: 2'd3, gnt: 2'd2, res: 1'b0, ack: 4'b0100};
    vecs[2] = '{req: 4'b0001, slot: 0, a: 2'd0, b: 2'd0, gnt: 2'd0, res: 1'b1, ack: 4'b0001};
    vecs[3] = '{req: 4'b0010, slot: 1, a: 2'd1, b: 2'd0, gnt: 2'd1, res: 1'b0, ack: 4'b0010};
    vecs[4] = '{req: 4'b0100, slot: 2, a: 2'd2, b: 2'd3, gnt: 2'd2, res: 1'b0, ack: 4'b0100};
    vecs[5] = '{req: 4'b1000, slot: 3, a: 2'd1, b: 2'd1, gnt: 2'd3, res: 1'b1, ack: 4'b1000};

    rst = 1'b1; req = '0; a_bus = 8'hA5; b_bus = 8'h3C;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_res", 32'(res), 32'd0);
    check("rst_gnt", 32'(gnt_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmp_a", 32'(cmp_a), 32'd0);
    check("rst_cmp_b", 32'(cmp_b), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table: other slots carry random operands that must not leak into the result
    for (int i = 0; i < 6; i++) begin
      ab = put_slot(8'($urandom), vecs[i].slot, vecs[i].a);
      bb = put_slot(8'($urandom), vecs[i].slot, vecs[i].b);
      e  = '{gnt: vecs[i].gnt, res: vecs[i].res, ack: vecs[i].ack, a: vecs[i].a, b: vecs[i].b};
      run_txn(vecs[i].req, ab, bb, e, 1'b1);
    end

    // Round robin, ptr starts at 0. Slots: a=0,1,2,3  b=3,1,2,3
    begin
      logic [IDW-1:0] rr_gnt [5];
      logic           rr_res [5];
      rr_gnt = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      rr_res = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
        e = '{gnt: rr_gnt[i], res: rr_res[i], ack: 4'b0001 << rr_gnt[i],
              a: W'(rr_gnt[i]), b: (rr_gnt[i] == 2'd0) ? 2'd3 : W'(rr_gnt[i])};
        run_txn(4'b1111, 8'hE4, 8'hE7, e, i == 4);
      end
    end

    // Move ptr to 3, then 0011 must wrap to requester 0
    run_txn(4'b0100, 8'h00, 8'h00, '{gnt: 2'd2, res: 1'b1, ack: 4'b0100, a: 2'd0, b: 2'd0}, 1'b1);
    run_txn(4'b0011, 8'h09, 8'h05, '{gnt: 2'd0, res: 1'b1, ack: 4'b0001, a: 2'd1, b: 2'd1}, 1'b1);

    // Operand change during COMPARE (ptr now 1)
    req = 4'b0010; a_bus = 8'h08; b_bus = 8'h08;
    @(negedge clk);
    check("opchg_busy", 32'(busy), 32'd1);
    check("opchg_gnt", 32'(gnt_id), 32'd1);
    check("opchg_cmp_a", 32'(cmp_a), 32'd2);
    a_bus = 8'h00;
    @(negedge clk);
    check("opchg_ack", 32'(ack), 32'b0010);
    check("opchg_res", 32'(res), 32'd1);
    n_txn++;
    $display("txn %0d operand change gnt=%0d res=%0d ack=%b", n_txn, gnt_id, res, ack);
    req = '0;
    @(negedge clk);
    check("opchg_release", 32'(ack), 32'd0);

    // Reset in HOLD (ptr now 2); afterwards 0101 must go to requester 0, not 2
    req = 4'b0100; a_bus = 8'h30; b_bus = 8'h30;
    repeat (2) @(negedge clk);
    check("rstmid_ack_before", 32'(ack), 32'b0100);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_ack", 32'(ack), 32'd0);
    check("rstmid_res", 32'(res), 32'd0);
    check("rstmid_gnt", 32'(gnt_id), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_cmp", 32'({cmp_a, cmp_b}), 32'd0);
    rst = 1'b0; req = '0;
    repeat (3) @(negedge clk);
    check("rstmid_no_ack", 32'(ack), 32'd0);
    n_txn++;
    $display("txn %0d reset mid-transaction ack=%b busy=%0d", n_txn, ack, busy);
    run_txn(4'b0101, 8'h13, 8'h12, '{gnt: 2'd0, res: 1'b0, ack: 4'b0001, a: 2'd3, b: 2'd2}, 1'b1);

    // Abort: req dropped during COMPARE (ptr now 1)
    req = 4'b1000; a_bus = 8'hC0; b_bus = 8'h40;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd1);
    req = '0;
    @(negedge clk);
    check("abort_ack", 32'(ack), 32'b1000);
    check("abort_res", 32'(res), 32'd0);
    @(negedge clk);
    check("abort_ack_drop", 32'(ack), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("abort_stay_idle", 32'({busy, ack}), 32'd0);
    n_txn++;
    $display("txn %0d abort gnt=%0d res=%0d", n_txn, gnt_id, res);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arbitro_comparador.md
Name: arbitro_comparador

Overview:
- Shares one combinational 2-bit equality comparator (`comparador`: inputs a, b; output aeqb) among NREQ requesters.
- Each requester presents an operand pair and raises req. The block grants one requester at a time with round-robin priority.
- It drives the comparator's operands, captures aeqb, and returns the result with a 4-phase req/ack handshake.
- Sits between requester logic and the single comparator instance at the same hierarchy level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 2, operand width per requester; must match the comparator input width.
- IDW, 2, width of the granted-ID output; must satisfy 2^IDW >= NREQ.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester request, level, 4-phase
- a_bus  input  NREQ*W  operand A; requester i uses bits [i*W +: W]
- b_bus  input  NREQ*W  operand B; requester i uses bits [i*W +: W]
- ack  output  NREQ  per-requester acknowledge, one-hot or zero, registered
- res  output  1  comparison result (1 = equal), valid while any ack bit is high
- gnt_id  output  IDW  index of current/last granted requester, registered
- busy  output  1  high when state is not IDLE
- cmp_a  output  W  registered operand A to the comparator
- cmp_b  output  W  registered operand B to the comparator
- cmp_aeqb  input  1  comparator result

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - ack=0, res=0, gnt_id=0, busy=0, cmp_a=0, cmp_b=0
  - state=IDLE, round-robin pointer ptr=0
- Reset takes priority over everything, including mid-transaction; no ack is issued for an interrupted transaction.
- FSM states: IDLE, COMPARE, HOLD.
- IDLE:
  - If req is nonzero, select the first set bit searching ptr, ptr+1, ..., wrapping modulo NREQ.
  - On the same edge: gnt_id <= winner; cmp_a/cmp_b <= winner's a_bus/b_bus slices; state <= COMPARE.
  - If req is zero, stay in IDLE and hold all outputs.
- COMPARE:
  - Exactly one cycle, so the comparator output settles on the registered operands.
  - Next edge: res <= cmp_aeqb; ack[gnt_id] <= 1; state <= HOLD.
- HOLD:
  - ack[gnt_id] and res are held.
  - When req[gnt_id]==0 at an edge: ack <= 0; ptr <= (gnt_id+1) mod NREQ; state <= IDLE.
  - res keeps its last value after ack drops.
- Latency:
  - req sampled in IDLE at edge k; ack and res visible after edge k+2.
  - Minimum transaction length is 4 cycles including the return to IDLE.
  - Next grant is possible at the edge after IDLE is re-entered.
- Operands are latched at grant. Requesters may change a/b after the grant edge without affecting the result.
- If req[gnt_id] drops during COMPARE (abort), the compare still completes. ack is high for exactly one cycle in HOLD, then the FSM returns to IDLE.
- Other req bits rising or falling during COMPARE/HOLD are ignored until IDLE.
- Round-robin fairness: with all req held high, grants cycle 0,1,...,NREQ-1,0 once each requester finishes its handshake.
- Selection is combinational over (req, ptr); ptr wraps from NREQ-1 to 0.

Optional Feature:
- Macro: ARB_CMP_STATS_EN.
- Defined:
  - Adds outputs n_cmp (16) and n_eq (16), both reset to 0.
  - n_cmp increments on each COMPARE->HOLD transition; n_eq increments on that edge when cmp_aeqb=1.
  - Both counters wrap 0xFFFF->0x0000.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then single request: req=0001, a_bus[1:0]=2, b_bus[1:0]=2 -> gnt_id=0, cmp_a=2, cmp_b=2, ack=0001 two edges after grant with res=1. Drop req -> ack=0 next edge, busy=0.
- Mismatch values: requester 2 with a=1, b=3 -> res=0, ack=0100. Also check a=0/b=0 -> 1, a=1/b=0 -> 0, a=1/b=1 -> 1, a=2/b=3 -> 0.
- Round robin: req=1111 held, each handshake completed -> gnt_id sequence 0,1,2,3,0. With ptr=3 and req=0011 -> gnt_id=0.
- Operand change after grant: change a_bus during COMPARE -> res reflects the latched operands.
- Abort: drop req during COMPARE -> ack high exactly 1 cycle, then IDLE.
- Reset mid-operation: assert rst in HOLD -> all outputs 0 next edge, ptr=0, no further ack. With ARB_CMP_STATS_EN, n_cmp=n_eq=0.
